// File: rtl/door_request_arbiter.sv
// ---------------------------------------------------------------------------
// door_request_arbiter
//
// Shares one door-sequencing datapath (sequencer FSM plus LED/7-seg output
// stage) between two door buttons. Rising edges on the request inputs are
// latched as pending flags. When the arbiter is idle it grants one door
// round-robin. It drives the door-select line and a one-cycle start pulse,
// then waits for the sequencer to leave IDLE and come back. A guard gap
// follows before the next grant.
//
// Panic pre-empts everything. A panic edge drops all pending requests and
// holds the arbiter until panic is released and the sequencer is idle.
//
// A watchdog bounds how long a grant may stay outstanding. When it expires
// it raises a sticky fault and returns the arbiter to service.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_0        door-0 request level (debounced), rising edge = request
//   req_1        door-1 request level (debounced), rising edge = request
//   panic_req    panic level (debounced)
//   state_reg    current sequencer state code
//   start        one-cycle pulse: sequencer begins a cycle for door `btn`
//   btn          door select (0 = door 0, 1 = door 1)
//   panic_start  one-cycle pulse on panic entry
//   busy         high whenever the arbiter is not in ARB_IDLE
//   pend         pending request flags {door1, door0}
//   timeout_err  sticky watchdog fault, cleared only by reset
// ---------------------------------------------------------------------------
module door_request_arbiter #(
  parameter int STATE_W   = 3,
  parameter int IDLE_CODE = 0,
  parameter int GUARD     = 4,
  parameter int TMO_W     = 24,
  parameter int TIMEOUT   = 16000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_0,
  input  logic               req_1,
  input  logic               panic_req,
  input  logic [STATE_W-1:0] state_reg,
  output logic               start,
  output logic               btn,
  output logic               panic_start,
  output logic               busy,
  output logic [1:0]         pend,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_LEAVE,
    ARB_WAIT_DONE,
    ARB_GUARD,
    ARB_PANIC
  } arb_state_t;

  localparam logic [STATE_W-1:0] IDLE_VAL = STATE_W'(IDLE_CODE);

  // Guard counter runs 0 .. GUARD-1, so GUARD cycles are spent in ARB_GUARD.
  localparam int             GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0]  GUARD_LAST = GW'(GUARD - 1);

  // The watchdog starts at 0 in the first wait cycle. The fault fires on the
  // edge where the count would reach TIMEOUT-1, so the comparison looks at
  // the value one below that.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  arb_state_t        arb_state;
  arb_state_t        arb_state_next;

  logic [1:0]        req_q;        // registered request levels, for edge detect
  logic              panic_q;      // registered panic level, for edge detect
  logic [1:0]        pend_q;
  logic              last_grant;
  logic              btn_q;
  logic [GW-1:0]     guard_cnt;
  logic [TMO_W-1:0]  wdog;
  logic              err_q;
  logic              panic_pulse;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [1:0]        req_rise;
  logic              panic_rise;
  logic              seq_idle;
  logic              in_grant;
  logic              in_wait;
  logic              wdog_expire;
  logic              grant_now;
  logic              grant_door;
  logic [1:0]        grant_mask;
  logic [1:0]        discard_mask;
  logic [1:0]        pend_next;

  assign req_rise   = {req_1, req_0} & ~req_q;
  assign panic_rise = panic_req & ~panic_q;
  assign seq_idle   = (state_reg == IDLE_VAL);

  // The door named by btn is "in service" from ISSUE through GUARD.
  assign in_grant   = (arb_state == ARB_ISSUE)      ||
                      (arb_state == ARB_WAIT_LEAVE) ||
                      (arb_state == ARB_WAIT_DONE)  ||
                      (arb_state == ARB_GUARD);
  assign in_wait    = (arb_state == ARB_WAIT_LEAVE) ||
                      (arb_state == ARB_WAIT_DONE);

  assign wdog_expire = in_wait && (wdog == TMO_LAST);

  // A panic edge outranks a grant that would otherwise happen on the same edge.
  assign grant_now  = (arb_state == ARB_IDLE) && (|pend_q) && !panic_rise;

  // Round-robin choice: a lone request wins outright. With both pending, the
  // door that did not get the last grant goes next.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    grant_door = 1'b0;
    unique case (pend_q)
      2'b01:   grant_door = 1'b0;
      2'b10:   grant_door = 1'b1;
      2'b11:   grant_door = ~last_grant;
      default: grant_door = 1'b0;
    endcase
  end

  assign grant_mask = grant_door ? 2'b10 : 2'b01;

  // Request edges that must not be latched. During panic, and on the panic
  // edge itself, both doors are dropped. While a door is in service, a repeat
  // press of that same door is meaningless.
  always_comb begin
    discard_mask = 2'b00;
    if (panic_rise || (arb_state == ARB_PANIC)) begin
      discard_mask = 2'b11;
    end else if (in_grant) begin
      discard_mask = btn_q ? 2'b10 : 2'b01;
    end
  end

  // Pending flags: new edges are OR-ed in, the granted door is cleared, and a
  // panic edge wipes everything. The clear wins over a same-edge re-request
  // of the door being granted, because that door is about to be served.
  always_comb begin
    pend_next = pend_q | (req_rise & ~discard_mask);
    if (grant_now) begin
      pend_next = pend_next & ~grant_mask;
    end
    if (panic_rise) begin
      pend_next = 2'b00;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state <= ARB_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments, so every register
      // samples pre-edge values no matter the statement order.
      arb_state <= arb_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    arb_state_next = arb_state;
    if (panic_rise) begin
      arb_state_next = ARB_PANIC;
    end else begin
      unique case (arb_state)
        ARB_IDLE: begin
          if (|pend_q) arb_state_next = ARB_ISSUE;
        end
        ARB_ISSUE: begin
          arb_state_next = ARB_WAIT_LEAVE;
        end
        ARB_WAIT_LEAVE: begin
          if (wdog_expire)    arb_state_next = ARB_GUARD;
          else if (!seq_idle) arb_state_next = ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          if (wdog_expire)    arb_state_next = ARB_GUARD;
          else if (seq_idle)  arb_state_next = ARB_GUARD;
        end
        ARB_GUARD: begin
          if (guard_cnt == GUARD_LAST) arb_state_next = ARB_IDLE;
        end
        ARB_PANIC: begin
          if (!panic_req && seq_idle) arb_state_next = ARB_GUARD;
        end
        default: arb_state_next = ARB_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    start       = (arb_state == ARB_ISSUE);
    busy        = (arb_state != ARB_IDLE);
    btn         = btn_q;
    pend        = pend_q;
    panic_start = panic_pulse;
    timeout_err = err_q;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 2'b00;
      panic_q     <= 1'b0;
      pend_q      <= 2'b00;
      last_grant  <= 1'b1;   // door 0 wins the first tie
      btn_q       <= 1'b0;
      guard_cnt   <= '0;
      wdog        <= '0;
      err_q       <= 1'b0;
      panic_pulse <= 1'b0;
    end else begin
      req_q       <= {req_1, req_0};
      panic_q     <= panic_req;
      pend_q      <= pend_next;
      panic_pulse <= panic_rise;

      // btn only moves on a grant. It is left alone on panic, so the output
      // stage keeps pointing at the last served door.
      if (grant_now) begin
        btn_q      <= grant_door;
        last_grant <= grant_door;
      end

      // Counts only while parked in ARB_GUARD. It re-arms from zero on every
      // entry, including the entry from panic.
      if (arb_state == ARB_GUARD) begin
        guard_cnt <= guard_cnt + 1'b1;
      end else begin
        guard_cnt <= '0;
      end

      // The watchdog restarts at each issue and runs only while waiting on
      // the sequencer. In panic it holds its value.
      if (arb_state == ARB_ISSUE) begin
        wdog <= '0;
      end else if (in_wait) begin
        wdog <= wdog + 1'b1;
      end

      if (wdog_expire && !panic_rise) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
